button_debouncer: RTL

- Conditions one raw mechanical push-button input for the button-control path, upstream of the edge detector.
- Pipeline: 2-FF synchronizer -> polarity normalization -> counter-qualified debounce FSM.
- Outputs: a clean active-high level for the edge detector, plus one-cycle press/release strobes for consumers that skip edge detection.

---
 rtl/button_debouncer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, polarity fix, counter-qualified debounce FSM.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to build the long-press strobe; otherwise long_press is 0.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 21,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic long_press
);

    localparam logic             REL_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync0, sync1;
    logic             s;
    logic             held;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= REL_LVL;
            sync1 <= REL_LVL;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
        end
    end

    assign s    = sync1 ^ REL_LVL;
    assign held = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LC_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LC_MAX  = CNT_W'(LONG_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
                        // hold timer saturates so it can only hit LC_LAST once per stint
                        if (cnt != LC_MAX) cnt <= cnt + CNT_ONE;
`else
                        cnt <= '0;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output stage trails the state by one register; strobes mark level changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= held;
            btn_press   <= held & ~btn_level;
            btn_release <= ~held & btn_level;
        end
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    logic lp_evt, lp_done, lp_hit;

    assign lp_hit = (state == PRESSED) && s && (cnt == LC_LAST) && !lp_done;

    // lp_done survives RELEASE_WAIT bounces; only a return to IDLE re-arms
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_evt     <= 1'b0;
            lp_done    <= 1'b0;
            long_press <= 1'b0;
        end else begin
            lp_evt     <= lp_hit;
            long_press <= lp_evt;
            if (lp_hit)              lp_done <= 1'b1;
            else if (state == IDLE)  lp_done <= 1'b0;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
